// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if: issue/retire/operand-check bundle between the pipeline and the register scoreboard
interface rf_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW = 5,
    parameter int NSRC = 2,
    parameter int TOT_W = 4
);
    logic issue_valid;
    logic issue_we;
    logic [AW-1:0] issue_dest;
    logic [NSRC-1:0] src_valid;
    logic [NSRC*AW-1:0] src_addr;
    logic [AW-1:0] dest_chk;
    logic dest_chk_we;
    logic retire_valid;
    logic retire_we;
    logic [AW-1:0] retire_dest;
    logic flush;
    logic stall;
    logic [NREG-1:0] busy_vec;
    logic [TOT_W-1:0] total_pend;
    logic err;
    modport master (
        output issue_valid, issue_we, issue_dest, src_valid, src_addr, dest_chk, dest_chk_we,
               retire_valid, retire_we, retire_dest, flush,
        input  stall, busy_vec, total_pend, err
    );
    modport slave (
        input  issue_valid, issue_we, issue_dest, src_valid, src_addr, dest_chk, dest_chk_we,
               retire_valid, retire_we, retire_dest, flush,
        output stall, busy_vec, total_pend, err
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: saturating per-register pending-write counters giving ID its RAW and overflow stalls
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW = 5,
    parameter int CNT_W = 2,
    parameter int NSRC = 2,
    parameter int TOT_W = 4
) (
    input logic clk,
    input logic reset,
    rf_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [TOT_W-1:0] TMAX = '1;
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [TOT_W-1:0] total;
    logic [NREG-1:0] busy;
    logic err_q, stall_c;
    logic [AW-1:0] id, rd, dc;
    logic inc, dec, same, inc_ok, dec_ok, inc_err, dec_err;

    function automatic logic [AW-1:0] reg_idx(input logic [AW-1:0] a);
        return (32'(a) < NREG) ? a : '0;
    endfunction

    assign id = reg_idx(sb.issue_dest);
    assign rd = reg_idx(sb.retire_dest);
    assign dc = reg_idx(sb.dest_chk);
    assign inc = sb.issue_valid & sb.issue_we & (id != '0);
    assign dec = sb.retire_valid & sb.retire_we & (rd != '0);
    assign same = inc & dec & (id == rd);
    assign inc_ok = inc & ~same & (cnt[id] != CMAX) & (total != TMAX);
    assign inc_err = inc & ~same & ~inc_ok;
    assign dec_ok = dec & ~same & (cnt[rd] != '0);
    assign dec_err = dec & ~same & (cnt[rd] == '0);

    // Register 0 is never incremented, so its zero count makes every r0 lookup harmless.
    always_comb begin
        stall_c = (total == TMAX) | (sb.dest_chk_we & (cnt[dc] == CMAX));
        for (int i = 0; i < NSRC; i++)
            stall_c = stall_c | (sb.src_valid[i] & (cnt[reg_idx(sb.src_addr[i*AW +: AW])] != '0));
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++)
            busy[r] = |cnt[r];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            total <= '0;
            err_q <= 1'b0;
        end else if (sb.flush) begin
            cnt <= '0;
            total <= '0;
        end else begin
            if (inc_ok) cnt[id] <= cnt[id] + 1'b1;
            if (dec_ok) cnt[rd] <= cnt[rd] - 1'b1;
            total <= total + TOT_W'(inc_ok) - TOT_W'(dec_ok);
            err_q <= err_q | inc_err | dec_err;
        end
    end

    assign sb.stall = stall_c;
    assign sb.busy_vec = busy;
    assign sb.total_pend = total;
    assign sb.err = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed and randomized checks of rf_scoreboard against an integer-count model
module tb_rf_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_bad = 0;
    int m[32];
    int mt;
    bit me;

    rf_scoreboard_if #(.NREG(32), .AW(5), .NSRC(2), .TOT_W(4)) bus ();
    rf_scoreboard #(.NREG(32), .AW(5), .CNT_W(2), .NSRC(2), .TOT_W(4)) dut (
        .clk(clk), .reset(reset), .sb(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        foreach (m[r]) m[r] = 0;
        mt = 0;
        me = 0;
    endfunction

    // Pending writes per register and in total, as plain integers.
    function automatic void model_edge();
        int i, d;
        if (bus.flush) begin
            foreach (m[r]) m[r] = 0;
            mt = 0;
            return;
        end
        i = (bus.issue_valid && bus.issue_we) ? int'(bus.issue_dest) : 0;
        d = (bus.retire_valid && bus.retire_we) ? int'(bus.retire_dest) : 0;
        if (i != 0 && i == d) return;
        if (i != 0) begin
            if (m[i] == 3 || mt == 15) me = 1;
            else begin m[i]++; mt++; end
        end
        if (d != 0) begin
            if (m[d] == 0) me = 1;
            else begin m[d]--; mt--; end
        end
    endfunction

    function automatic logic model_stall();
        logic s;
        s = (mt == 15);
        if (bus.dest_chk_we && bus.dest_chk != 0 && m[bus.dest_chk] == 3) s = 1;
        for (int i = 0; i < 2; i++)
            if (bus.src_valid[i] && bus.src_addr[i*5 +: 5] != 0 && m[bus.src_addr[i*5 +: 5]] != 0) s = 1;
        return s;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = (m[r] != 0);
        return b;
    endfunction

    task automatic idle();
        bus.issue_valid = 0; bus.issue_we = 0; bus.issue_dest = 0;
        bus.src_valid = 0; bus.src_addr = 0; bus.dest_chk = 0; bus.dest_chk_we = 0;
        bus.retire_valid = 0; bus.retire_we = 0; bus.retire_dest = 0; bus.flush = 0;
    endtask

    task automatic issue(input int r);
        bus.issue_valid = 1; bus.issue_we = 1; bus.issue_dest = 5'(r);
    endtask

    task automatic retire(input int r);
        bus.retire_valid = 1; bus.retire_we = 1; bus.retire_dest = 5'(r);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        reset = 0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        n_chk++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL reset_busy got=%h exp=0", bus.busy_vec); end
        n_chk++; if (bus.total_pend !== 4'h0) begin n_bad++; $display("FAIL reset_total got=%0d exp=0", bus.total_pend); end
        n_chk++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        @(posedge clk);
        #3;
        reset = 0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        idle(); issue(5); tick();
        idle(); bus.src_valid = 2'b01; bus.src_addr = {5'd0, 5'd5};
        #1;
        n_chk++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL basic_raw_stall got=%b exp=1", bus.stall); end
        n_chk++; if (bus.busy_vec[5] !== 1'b1) begin n_bad++; $display("FAIL basic_busy5 got=%b exp=1", bus.busy_vec[5]); end
        n_chk++; if (bus.total_pend !== 4'd1) begin n_bad++; $display("FAIL basic_total got=%0d exp=1", bus.total_pend); end
        retire(5);
        #1;
        n_chk++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL basic_no_bypass got=%b exp=1", bus.stall); end
        tick();
        bus.retire_valid = 0; bus.retire_we = 0;
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL basic_stall_clear got=%b exp=0", bus.stall); end
        n_chk++; if (bus.total_pend !== 4'd0) begin n_bad++; $display("FAIL basic_total_clear got=%0d exp=0", bus.total_pend); end
    endtask

    task automatic test_zero();
        idle(); issue(0); tick();
        idle(); bus.src_valid = 2'b11; bus.src_addr = {5'd0, 5'd0};
        #1;
        n_chk++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL zero_stall got=%b exp=0", bus.stall); end
        n_chk++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL zero_busy got=%h exp=0", bus.busy_vec); end
        n_chk++; if (bus.total_pend !== 4'd0) begin n_bad++; $display("FAIL zero_total got=%0d exp=0", bus.total_pend); end
    endtask

    task automatic test_same_cycle();
        idle(); issue(9); tick();
        issue(9); retire(9); tick();
        idle();
        n_chk++; if (bus.busy_vec[9] !== 1'b1) begin n_bad++; $display("FAIL same_busy9 got=%b exp=1", bus.busy_vec[9]); end
        n_chk++; if (bus.total_pend !== 4'd1) begin n_bad++; $display("FAIL same_total got=%0d exp=1", bus.total_pend); end
        issue(4); tick();
        idle(); issue(3); retire(4); tick();
        idle();
        n_chk++; if (bus.busy_vec[4:3] !== 2'b01) begin n_bad++; $display("FAIL split_busy43 got=%b exp=01", bus.busy_vec[4:3]); end
        n_chk++; if (bus.total_pend !== 4'd2) begin n_bad++; $display("FAIL split_total got=%0d exp=2", bus.total_pend); end
        retire(3); tick();
        idle(); retire(9); tick();
        idle();
        n_chk++; if (bus.busy_vec !== 32'h0 || bus.total_pend !== 4'd0) begin
            n_bad++; $display("FAIL same_drain got busy=%h total=%0d exp busy=0 total=0", bus.busy_vec, bus.total_pend);
        end
        n_chk++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL same_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_saturate();
        idle();
        for (int k = 0; k < 3; k++) begin issue(7); tick(); end
        idle(); bus.dest_chk = 7; bus.dest_chk_we = 1;
        #1;
        n_chk++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall got=%b exp=1", bus.stall); end
        issue(7); tick();
        bus.issue_valid = 0;
        #1;
        n_chk++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL sat_err got=%b exp=1", bus.err); end
        n_chk++; if (bus.total_pend !== 4'd3) begin n_bad++; $display("FAIL sat_total got=%0d exp=3", bus.total_pend); end
        n_chk++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL sat_still got=%b exp=1", bus.stall); end
        idle();
        for (int k = 0; k < 3; k++) begin retire(7); tick(); end
        idle();
        n_chk++; if (bus.busy_vec !== 32'h0 || bus.total_pend !== 4'd0) begin
            n_bad++; $display("FAIL sat_drain got busy=%h total=%0d exp busy=0 total=0", bus.busy_vec, bus.total_pend);
        end
    endtask

    task automatic test_total_max();
        idle();
        for (int r = 1; r <= 5; r++)
            for (int k = 0; k < 3; k++) begin issue(r); tick(); end
        idle();
        #1;
        n_chk++; if (bus.total_pend !== 4'd15) begin n_bad++; $display("FAIL tmax_total got=%0d exp=15", bus.total_pend); end
        n_chk++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL tmax_stall got=%b exp=1", bus.stall); end
        issue(6); tick();
        idle();
        n_chk++; if (bus.busy_vec[6] !== 1'b0 || bus.total_pend !== 4'd15) begin
            n_bad++; $display("FAIL tmax_drop got busy6=%b total=%0d exp busy6=0 total=15", bus.busy_vec[6], bus.total_pend);
        end
        retire(1); tick();
        idle();
        n_chk++; if (bus.total_pend !== 4'd14 || bus.stall !== 1'b0) begin
            n_bad++; $display("FAIL tmax_release got total=%0d stall=%b exp total=14 stall=0", bus.total_pend, bus.stall);
        end
    endtask

    task automatic test_underflow();
        idle(); issue(2); tick();
        idle(); retire(12); tick();
        idle();
        n_chk++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL under_err got=%b exp=1", bus.err); end
        n_chk++; if (bus.total_pend !== 4'd1) begin n_bad++; $display("FAIL under_total got=%0d exp=1", bus.total_pend); end
        tick(); tick();
        n_chk++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL under_sticky got=%b exp=1", bus.err); end
    endtask

    task automatic test_flush();
        idle();
        for (int r = 1; r <= 3; r++) begin issue(r); tick(); end
        idle(); bus.flush = 1; issue(4); tick();
        idle();
        n_chk++; if (bus.busy_vec !== 32'h0) begin n_bad++; $display("FAIL flush_busy got=%h exp=0", bus.busy_vec); end
        n_chk++; if (bus.total_pend !== 4'd0) begin n_bad++; $display("FAIL flush_total got=%0d exp=0", bus.total_pend); end
        n_chk++; if (bus.err !== me) begin n_bad++; $display("FAIL flush_err got=%b exp=%b", bus.err, me); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bus.issue_valid = ($urandom % 10) < 6;
            bus.issue_we = ($urandom % 8) != 0;
            bus.issue_dest = 5'($urandom_range(0, 7));
            bus.src_valid = 2'($urandom);
            bus.src_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.dest_chk = 5'($urandom_range(0, 7));
            bus.dest_chk_we = 1'($urandom);
            bus.retire_valid = ($urandom % 10) < 5;
            bus.retire_we = ($urandom % 8) != 0;
            bus.retire_dest = 5'($urandom_range(0, 7));
            bus.flush = ($urandom % 60) == 0;
            #1;
            n_chk++; if (bus.stall !== model_stall()) begin
                n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, bus.stall, model_stall());
            end
            tick();
            n_chk++; if (bus.busy_vec !== model_busy() || bus.total_pend !== 4'(mt) || bus.err !== me) begin
                n_bad++;
                $display("FAIL rnd_state cyc=%0d got busy=%h total=%0d err=%b exp busy=%h total=%0d err=%b",
                         c, bus.busy_vec, bus.total_pend, bus.err, model_busy(), mt, me);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); issue(2); tick();
        idle(); retire(12); tick();
        idle(); bus.src_valid = 2'b10; bus.src_addr = {5'd2, 5'd0};
        #1;
        n_chk++; if (bus.stall !== 1'b1 || bus.err !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre got stall=%b err=%b exp stall=1 err=1", bus.stall, bus.err);
        end
        reset = 1;
        #1;
        n_chk++; if (bus.stall !== 1'b0 || bus.busy_vec !== 32'h0 || bus.total_pend !== 4'd0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_now got stall=%b busy=%h total=%0d err=%b exp all 0",
                     bus.stall, bus.busy_vec, bus.total_pend, bus.err);
        end
        #1;
        reset = 0;
        model_clear();
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_same_cycle();
        test_saturate();
        test_total_max();
        do_reset();
        test_underflow();
        test_flush();
        do_reset();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
